// File: rtl/aes_pkg.sv
// Shared AES controller types: key-size modes, round counts and the sequencer state encoding.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_128 = 2'b00,
    MODE_192 = 2'b01,
    MODE_256 = 2'b10
  } aes_mode_t;

  localparam logic [3:0] AES_NR_128 = 4'd10;
  localparam logic [3:0] AES_NR_192 = 4'd12;
  localparam logic [3:0] AES_NR_256 = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_R0     = 3'd1,
    ST_FEED   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } aes_ctrl_state_t;

  // The unused 2'b11 encoding is folded onto AES-256.
  function automatic aes_mode_t aes_mode_norm(input logic [1:0] mode);
    case (mode)
      2'b00:   return MODE_128;
      2'b01:   return MODE_192;
      default: return MODE_256;
    endcase
  endfunction

  function automatic logic [3:0] aes_nr(input aes_mode_t mode);
    case (mode)
      MODE_128: return AES_NR_128;
      MODE_192: return AES_NR_192;
      default:  return AES_NR_256;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-in / ciphertext-out valid/ready bus of the AES round sequencer.
interface aes_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_round_cnt.sv
// Round and word counters for the AES sequencer, with last-word / last-round flags.
module aes_round_cnt #(
  parameter int unsigned WORD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic       word_inc,
  input  logic       round_inc,
  input  logic [3:0] nr,
  output logic [3:0] round,
  output logic [1:0] word,
  output logic       last_word,
  output logic       last_round
);

  localparam logic [1:0] LAST_WORD = 2'(WORD_CYCLES - 1);

  assign last_word  = (word == LAST_WORD);
  assign last_round = (round == nr);

  // The word counter parks on its last value; only a round step returns it to 0.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      round <= '0;
      word  <= '0;
    end else if (load) begin
      round <= 4'd1;
      word  <= '0;
    end else if (round_inc && !last_round) begin
      round <= round + 4'd1;
      word  <= '0;
    end else if (word_inc && !last_word) begin
      word <= word + 2'd1;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: holds the state register and steps the 32-bit-radix datapath
// through rounds 0..Nr. Optional abort input under AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned WORD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_round_ctrl_if.slave     io,
  output logic                busy,
  output logic [3:0]          rd_round,
  output logic [1:0]          rd_width_sel,
  output logic [1:0]          rd_mode,
  output logic [127:0]        rd_data_in,
  input  logic [127:0]        rd_data_out
`ifdef AES_ROUND_CTRL_ABORT_EN
  ,
  input  logic                abort
`endif
);

  aes_ctrl_state_t state_q;
  aes_mode_t       mode_q;
  logic [3:0]      nr_q;
  logic [127:0]    data_q;
  logic [3:0]      round;
  logic [1:0]      word;
  logic            last_word;
  logic            last_round;
  logic            abort_req;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_req = abort && (state_q != ST_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  aes_round_cnt #(.WORD_CYCLES(WORD_CYCLES)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        ((state_q == ST_IDLE) || abort_req),
    .load       (state_q == ST_R0),
    .word_inc   (state_q == ST_FEED),
    .round_inc  (state_q == ST_COMMIT),
    .nr         (nr_q),
    .round      (round),
    .word       (word),
    .last_word  (last_word),
    .last_round (last_round)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_128;
      nr_q    <= AES_NR_128;
      data_q  <= '0;
    end else if (abort_req) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (io.in_valid) begin
          data_q  <= io.in_data;
          mode_q  <= aes_mode_norm(io.in_mode);
          nr_q    <= aes_nr(aes_mode_norm(io.in_mode));
          state_q <= ST_R0;
        end
        ST_R0: begin
          data_q  <= rd_data_out;
          state_q <= ST_FEED;
        end
        ST_FEED: if (last_word) state_q <= ST_COMMIT;
        ST_COMMIT: begin
          data_q  <= rd_data_out;
          state_q <= last_round ? ST_DONE : ST_FEED;
        end
        ST_DONE: if (io.out_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state_q == ST_IDLE);
  assign io.out_valid = (state_q == ST_DONE);
  // Ciphertext is only exposed once complete, so intermediate rounds never leak.
  assign io.out_data  = (state_q == ST_DONE) ? data_q : '0;
  assign busy         = (state_q != ST_IDLE);
  assign rd_round     = (state_q == ST_R0 || state_q == ST_FEED || state_q == ST_COMMIT) ? round : '0;
  assign rd_width_sel = (state_q == ST_FEED) ? word : '0;
  assign rd_mode      = mode_q;
  assign rd_data_in   = data_q;

endmodule
